alu_div_seq: RTL and testbench
==============================

# alu_div_seq

Parametrised iterative divider with integrated sequencer for the 8088 ALU, successor to the fixed 16-step divide sequencer. It performs one restoring-division step per clock on a 2W-bit dividend and W-bit divisor, in unsigned (DIV) or signed (IDIV) mode. It detects 8088 divide errors (zero divisor, quotient overflow) and reports completion with a start/done handshake. It sits beside the ALU datapath and is launched by the ALU control on DIV/IDIV opcodes.

## Interface
- W, default 8: divisor, quotient and remainder width; dividend is 2W. Legal values 4..32.
- CLK  in  1  clock; all state updates on the falling edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  launch request; sampled only in IDLE.
- SGN  in  1  1 = signed (IDIV), 0 = unsigned (DIV); captured with START.
- DIVIDEND  in  2W  dividend; captured with START.
- DIVISOR  in  W  divisor; captured with START.
- QUO  out  W  quotient; reset 0.
- REM  out  W  remainder; reset 0.
- RDY  out  1  high in IDLE only; reset 1.
- DONE  out  1  one-cycle completion pulse; reset 0.
- DERR  out  1  divide error, valid with DONE, held until next accepted START; reset 0.

## Operation
- States: IDLE, CHECK, ITER, FIX, DONE.
- IDLE:
  - RDY=1.
  - START=1 captures operands and SGN; go to CHECK.
  - START=0 stays in IDLE.
- CHECK:
  - Form magnitudes: |dividend| (2W bits) and |divisor| (W bits). In unsigned mode the magnitudes are the raw values.
  - Error if divisor==0, or if high half of |dividend| >= |divisor|. On error: go to DONE with DERR=1.
  - Otherwise: partial remainder P (W+1 bits) = high half of |dividend|, shift register Q = low half, step counter = W; go to ITER.
- ITER (exactly W cycles):
  - P = {P[W-1:0], Q[W-1]}; Q shifts left.
  - If P >= |divisor|: P -= |divisor| and Q[0]=1.
  - Counter decrements; at 0 go to FIX.
- FIX:
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend). Truncating division.
  - Signed overflow: positive quotient with magnitude > 2^(W-1)-1, or negative quotient with magnitude > 2^(W-1), sets DERR=1.
  - Without error, apply signs and load QUO/REM.
  - Go to DONE.
- DONE:
  - DONE=1 for one cycle; go to IDLE.
  - On DERR, QUO/REM keep their previous values.
- START outside IDLE is ignored; no queuing.
- START held high continuously launches a new operation on every IDLE cycle.
- RST at any time forces IDLE and restores all reset values; an in-flight result is discarded.

## Timing
- Normal completion: DONE high in the cycle starting W+2 falling edges after the edge that samples START (CHECK 1 + ITER W + FIX 1). For W=8, that is 10 edges.
- Early error (zero divisor or high-half overflow): DONE after 2 edges.
- Signed-overflow error: DONE after W+2 edges.
- RDY falls on the edge that samples START and rises on the edge that leaves DONE.
- Back-to-back operation: minimum START-to-START spacing is W+3 edges.
- QUO, REM and DERR change only on the edge entering DONE.

## Structure
- Shared header alu_div_defs.vh holds the state encodings (3-bit localparams IDLE=0, CHECK=1, ITER=2, FIX=3, DONE=4) and the opcode-to-SGN mapping used by ALU control.
- One sub-module, alu_div_step: combinational single restoring step, parameter W. Inputs P, Q msb, |divisor|; outputs next P and quotient bit.
- The top level contains the FSM, step counter, operand/sign registers, magnitude and sign-fix logic.

## Test plan
- W=8, unsigned, DIVIDEND=0x03E8, DIVISOR=0x07 -> after 10 edges DONE=1, QUO=0x8E, REM=0x06, DERR=0.
- W=8, unsigned, 0x1234/0x00 -> DONE after 2 edges, DERR=1, QUO/REM unchanged. Repeat with 0x0800/0x08 -> same early DERR.
- W=8, signed, 0xFFF9/0x02 (-7/2) -> QUO=0xFD, REM=0xFF. Also 0xFF00/0x02 -> QUO=0x80, REM=0x00, DERR=0.
- W=8, signed, 0x0100/0x02 (+128) -> DERR=1 with DONE after 10 edges.
- START held high: second operation accepted only after RDY returns. START pulses during ITER are ignored.
- RST asserted mid-ITER -> immediate RDY=1, DONE=0, DERR=0, QUO=REM=0. The next START completes normally.
- Randomised sweep at W=4 and W=16 against a reference model, in both modes.

Source files
------------

// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// ALU opcode decode that selects DIV versus IDIV.
package alu_div_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ITER  = 3'd2,
      S_FIX   = 3'd3,
      S_DONE  = 3'd4
   } div_state_e;

   // Group-3 reg field of the 8088 F6/F7 opcodes.
   localparam logic [2:0] OP_DIV  = 3'd6;
   localparam logic [2:0] OP_IDIV = 3'd7;

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_IDIV);
   endfunction

endpackage

// File: rtl/alu_div_seq_if.sv
// Launch/result bundle between the ALU control (master) and the divider (slave).
interface alu_div_seq_if #(
   parameter int W = 8
);
   logic           START;
   logic           SGN;
   logic [2*W-1:0] DIVIDEND;
   logic [W-1:0]   DIVISOR;
   logic [W-1:0]   QUO;
   logic [W-1:0]   REM;
   logic           RDY;
   logic           DONE;
   logic           DERR;

   modport master (
      output START, SGN, DIVIDEND, DIVISOR,
      input  QUO, REM, RDY, DONE, DERR
   );

   modport slave (
      input  START, SGN, DIVIDEND, DIVISOR,
      output QUO, REM, RDY, DONE, DERR
   );
endinterface

// File: rtl/alu_div_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module alu_div_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] p_i,
   input  logic         q_msb_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] p_o,
   output logic         q_bit_o
);
   logic [W:0] p_sh_s;

   assign p_sh_s  = {p_i, q_msb_i};
   assign q_bit_o = (p_sh_s >= {1'b0, dvs_i});
   // The difference is below dvs_i, so dropping the carry bit is exact.
   assign p_o     = q_bit_o ? (p_sh_s[W-1:0] - dvs_i) : p_sh_s[W-1:0];
endmodule

// File: rtl/alu_div_seq.sv
// Iterative signed/unsigned divider for the 8088 ALU: 2W/W restoring division,
// one step per falling clock edge, with divide-error detection.
module alu_div_seq
   import alu_div_seq_pkg::*;
#(
   parameter int W = 8
) (
   input logic          CLK,
   input logic          RST,
   alu_div_seq_if.slave bus
);
   localparam int         CW  = $clog2(W + 1);
   localparam logic [W-1:0] LIM = {1'b1, {(W-1){1'b0}}};

   div_state_e     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sgn_q, sgn_d;
   logic [2*W-1:0] dvd_q, dvd_d;
   logic [W-1:0]   dvs_q, dvs_d;
   logic [W-1:0]   p_q, p_d;
   logic [W-1:0]   q_q, q_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic           err_q, err_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   rem_q, rem_d;
   logic           derr_q, derr_d;
   logic           rdy_q, rdy_d;
   logic           done_q, done_d;

   logic [2*W-1:0] dvd_mag_s;
   logic [W-1:0]   dvs_mag_s;
   logic [W-1:0]   p_step_s;
   logic           q_bit_s;
   logic           q_ovf_s;

   alu_div_step #(.W(W)) u_step (
      .p_i     (p_q),
      .q_msb_i (q_q[W-1]),
      .dvs_i   (dvs_q),
      .p_o     (p_step_s),
      .q_bit_o (q_bit_s)
   );

   // Magnitudes are only meaningful in CHECK, while dvd_q/dvs_q still hold raw operands.
   assign dvd_mag_s = (sgn_q && dvd_q[2*W-1]) ? -dvd_q : dvd_q;
   assign dvs_mag_s = (sgn_q && dvs_q[W-1])   ? -dvs_q : dvs_q;
   assign q_ovf_s   = sgn_q && (qneg_q ? (q_q > LIM) : q_q[W-1]);

   // Next-state, datapath and output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      p_d     = p_q;
      q_d     = q_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      err_d   = err_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      derr_d  = derr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               sgn_d   = bus.SGN;
               dvd_d   = bus.DIVIDEND;
               dvs_d   = bus.DIVISOR;
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            qneg_d = sgn_q & (dvd_q[2*W-1] ^ dvs_q[W-1]);
            rneg_d = sgn_q & dvd_q[2*W-1];
            dvs_d  = dvs_mag_s;
            p_d    = dvd_mag_s[2*W-1:W];
            q_d    = dvd_mag_s[W-1:0];
            cnt_d  = CW'(W);
            // Early errors still pass through FIX so every result lands on the DONE-entry edge.
            if ((dvs_mag_s == {W{1'b0}}) || (dvd_mag_s[2*W-1:W] >= dvs_mag_s)) begin
               err_d   = 1'b1;
               state_d = S_FIX;
            end else begin
               err_d   = 1'b0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            p_d   = p_step_s;
            q_d   = {q_q[W-2:0], q_bit_s};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FIX;
            end else begin
               state_d = S_ITER;
            end
         end
         S_FIX: begin
            state_d = S_DONE;
            if (err_q || q_ovf_s) begin
               derr_d = 1'b1;
            end else begin
               derr_d = 1'b0;
               quo_d  = qneg_q ? -q_q : q_q;
               rem_d  = rneg_q ? -p_q : p_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      rdy_d  = (state_d == S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers, updated on the falling edge.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         sgn_q   <= 1'b0;
         dvd_q   <= {(2*W){1'b0}};
         dvs_q   <= {W{1'b0}};
         p_q     <= {W{1'b0}};
         q_q     <= {W{1'b0}};
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         err_q   <= 1'b0;
         quo_q   <= {W{1'b0}};
         rem_q   <= {W{1'b0}};
         derr_q  <= 1'b0;
         rdy_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         p_q     <= p_d;
         q_q     <= q_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         err_q   <= err_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         derr_q  <= derr_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
      end
   end

   assign bus.QUO  = quo_q;
   assign bus.REM  = rem_q;
   assign bus.RDY  = rdy_q;
   assign bus.DONE = done_q;
   assign bus.DERR = derr_q;
endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq at W=8 (directed) and W=4/W=16 (random),
// using a scoreboard queue filled at launch and drained at DONE.
module tb_alu_div_seq;
   typedef struct {
      int          w;
      bit          err;
      logic [31:0] quo;
      logic [31:0] rem;
      int          lat;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [31:0] last_q [3];
   logic [31:0] last_r [3];

   always #5 CLK = ~CLK;

   alu_div_seq_if #(.W(4))  if4 ();
   alu_div_seq_if #(.W(8))  if8 ();
   alu_div_seq_if #(.W(16)) if16 ();

   alu_div_seq #(.W(4))  u4  (.CLK(CLK), .RST(RST), .bus(if4));
   alu_div_seq #(.W(8))  u8  (.CLK(CLK), .RST(RST), .bus(if8));
   alu_div_seq #(.W(16)) u16 (.CLK(CLK), .RST(RST), .bus(if16));

   function automatic int idx(int w);
      return (w == 4) ? 0 : ((w == 8) ? 1 : 2);
   endfunction

   // Reference: plain integer division on sign-extended operands.
   function automatic exp_t model(int w, bit sgn, longint dvd, longint dvs);
      exp_t   e;
      longint m2, m1, sd, sv, ad, av, q, r, lim;
      m2  = (longint'(1) << (2 * w)) - 1;
      m1  = (longint'(1) << w) - 1;
      lim = longint'(1) << (w - 1);
      sd  = dvd & m2;
      sv  = dvs & m1;
      if (sgn && sd >= (longint'(1) << (2 * w - 1))) sd = sd - (m2 + 1);
      if (sgn && sv >= lim) sv = sv - (m1 + 1);
      ad = (sd < 0) ? -sd : sd;
      av = (sv < 0) ? -sv : sv;
      e.w = w;
      e.err = 1'b0;
      e.lat = w + 2;
      q = 0;
      r = 0;
      if (av == 0 || ad >= (av << w)) begin
         e.err = 1'b1;
         e.lat = 2;
      end else begin
         q = sd / sv;
         r = sd % sv;
         if (sgn && (q > lim - 1 || q < -lim)) e.err = 1'b1;
      end
      if (e.err) begin
         e.quo = last_q[idx(w)];
         e.rem = last_r[idx(w)];
      end else begin
         e.quo = 32'(q & m1);
         e.rem = 32'(r & m1);
         last_q[idx(w)] = e.quo;
         last_r[idx(w)] = e.rem;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put_in(input int w, input bit st, input bit sgn, input longint dvd, input longint dvs);
      case (w)
         4: begin
            if4.START = st; if4.SGN = sgn; if4.DIVIDEND = 8'(dvd); if4.DIVISOR = 4'(dvs);
         end
         8: begin
            if8.START = st; if8.SGN = sgn; if8.DIVIDEND = 16'(dvd); if8.DIVISOR = 8'(dvs);
         end
         default: begin
            if16.START = st; if16.SGN = sgn; if16.DIVIDEND = 32'(dvd); if16.DIVISOR = 16'(dvs);
         end
      endcase
   endtask

   task automatic sample(input int w, output logic d, output logic rdy, output logic er,
                         output logic [31:0] q, output logic [31:0] rm);
      case (w)
         4: begin
            d = if4.DONE; rdy = if4.RDY; er = if4.DERR; q = 32'(if4.QUO); rm = 32'(if4.REM);
         end
         8: begin
            d = if8.DONE; rdy = if8.RDY; er = if8.DERR; q = 32'(if8.QUO); rm = 32'(if8.REM);
         end
         default: begin
            d = if16.DONE; rdy = if16.RDY; er = if16.DERR; q = 32'(if16.QUO); rm = 32'(if16.REM);
         end
      endcase
   endtask

   task automatic wait_rdy(input int w);
      logic d, rdy, er;
      logic [31:0] q, rm;
      int n;
      n = 0;
      sample(w, d, rdy, er, q, rm);
      while (rdy !== 1'b1 && n < 40) begin
         @(posedge CLK);
         sample(w, d, rdy, er, q, rm);
         n++;
      end
      chk("rdy_before_start", rdy, 1);
   endtask

   // Counts falling edges after the START-sampling edge until DONE is seen.
   task automatic wait_done(input int w, input int n0);
      exp_t e;
      int   n;
      bit   seen;
      logic d, rdy, er;
      logic [31:0] q, rm;
      n = n0;
      seen = 1'b0;
      d = 1'b0; rdy = 1'b0; er = 1'b0; q = 32'd0; rm = 32'd0;
      while (!seen && n < 80) begin
         @(negedge CLK);
         n++;
         @(posedge CLK);
         sample(w, d, rdy, er, q, rm);
         if (d === 1'b1) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 1);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("latency", n, e.lat);
         chk("derr", er, e.err);
         chk("quo", q, e.quo);
         chk("rem", rm, e.rem);
         chk("rdy_low_in_done", rdy, 0);
      end
   endtask

   task automatic start_op(input int w, input bit sgn, input longint dvd, input longint dvs);
      logic d, rdy, er;
      logic [31:0] q, rm;
      wait_rdy(w);
      sb.push_back(model(w, sgn, dvd, dvs));
      put_in(w, 1'b1, sgn, dvd, dvs);
      @(negedge CLK);
      #1;
      put_in(w, 1'b0, sgn, dvd, dvs);
      sample(w, d, rdy, er, q, rm);
      chk("rdy_fall", rdy, 0);
      wait_done(w, 0);
   endtask

   initial begin
      logic d, rdy, er;
      logic [31:0] q, rm;
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         last_q[i] = 32'd0;
         last_r[i] = 32'd0;
      end
      put_in(4, 1'b0, 1'b0, 0, 0);
      put_in(8, 1'b0, 1'b0, 0, 0);
      put_in(16, 1'b0, 1'b0, 0, 0);
      repeat (3) @(posedge CLK);
      sample(8, d, rdy, er, q, rm);
      chk("rst_rdy", rdy, 1);
      chk("rst_done", d, 0);
      chk("rst_derr", er, 0);
      chk("rst_quo", q, 0);
      chk("rst_rem", rm, 0);
      sample(4, d, rdy, er, q, rm);
      chk("rst_rdy4", rdy, 1);
      sample(16, d, rdy, er, q, rm);
      chk("rst_rdy16", rdy, 1);
      RST = 1'b0;
      @(posedge CLK);

      // Directed W=8 cases
      start_op(8, 1'b0, 64'h03E8, 64'h07);
      start_op(8, 1'b0, 64'h1234, 64'h00);
      start_op(8, 1'b0, 64'h0800, 64'h08);
      start_op(8, 1'b1, 64'hFFF9, 64'h02);
      start_op(8, 1'b1, 64'hFF00, 64'h02);
      start_op(8, 1'b1, 64'h0100, 64'h02);
      start_op(8, 1'b1, 64'h0064, 64'hF9);

      // START held high: second launch only once RDY returns
      wait_rdy(8);
      sb.push_back(model(8, 1'b0, 64'h1234, 64'h56));
      sb.push_back(model(8, 1'b0, 64'h1234, 64'h56));
      put_in(8, 1'b1, 1'b0, 64'h1234, 64'h56);
      @(negedge CLK);
      wait_done(8, 0);
      @(negedge CLK);
      @(posedge CLK);
      sample(8, d, rdy, er, q, rm);
      chk("held_rdy_idle", rdy, 1);
      @(negedge CLK);
      @(posedge CLK);
      sample(8, d, rdy, er, q, rm);
      chk("held_relaunch", rdy, 0);
      put_in(8, 1'b0, 1'b0, 64'h1234, 64'h56);
      wait_done(8, 0);

      // START pulse during ITER is ignored
      wait_rdy(8);
      sb.push_back(model(8, 1'b0, 64'h03EB, 64'h07));
      put_in(8, 1'b1, 1'b0, 64'h03EB, 64'h07);
      @(negedge CLK);
      #1;
      put_in(8, 1'b0, 1'b0, 64'h03EB, 64'h07);
      repeat (3) @(negedge CLK);
      #1;
      put_in(8, 1'b1, 1'b1, 64'hFFFF, 64'h03);
      @(negedge CLK);
      #1;
      put_in(8, 1'b0, 1'b0, 64'h0, 64'h0);
      wait_done(8, 4);
      repeat (2) @(posedge CLK);
      sample(8, d, rdy, er, q, rm);
      chk("no_queued_launch", rdy, 1);

      // Leave DERR set, then reset mid-ITER
      start_op(8, 1'b1, 64'h0100, 64'h02);
      wait_rdy(8);
      put_in(8, 1'b1, 1'b0, 64'h1000, 64'h21);
      @(negedge CLK);
      #1;
      put_in(8, 1'b0, 1'b0, 64'h1000, 64'h21);
      repeat (3) @(negedge CLK);
      @(posedge CLK);
      RST = 1'b1;
      #1;
      sample(8, d, rdy, er, q, rm);
      chk("mid_rst_rdy", rdy, 1);
      chk("mid_rst_done", d, 0);
      chk("mid_rst_derr", er, 0);
      chk("mid_rst_quo", q, 0);
      chk("mid_rst_rem", rm, 0);
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         last_q[i] = 32'd0;
         last_r[i] = 32'd0;
      end
      @(posedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      start_op(8, 1'b0, 64'h1000, 64'h21);

      // Random sweeps at W=4 and W=16, both modes
      for (int pass = 0; pass < 2; pass++) begin
         int w;
         w = (pass == 0) ? 4 : 16;
         for (int i = 0; i < 30; i++) begin
            longint dvd, dvs, m1, m2;
            int k;
            m1  = (longint'(1) << w) - 1;
            m2  = (longint'(1) << (2 * w)) - 1;
            dvs = longint'($urandom) & m1;
            dvd = {$urandom, $urandom} & m2;
            k   = $urandom_range(0, 2);
            if (k == 1) dvd = dvd >> (w + 1);
            if (k == 2) dvd = m2 - (dvd >> (w + 1));
            start_op(w, 1'($urandom_range(0, 1)), dvd, dvs);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
